// File: rtl/la32r_inst_encoder.sv
// LA32R instruction encoder: turns an abstract op (op code, rd/rj/rk, 32-bit
// immediate) into the matching 32-bit instruction word through a registered,
// ready/valid output stage. li.w expands into one or two words. Illegal ops and
// bad immediates produce break 0 (002A0000) with out_err set.
//
// state | meaning
// IDLE  | accepting requests whenever the output register can take a word
// EMIT2 | holding the latched ori word of a two-word li.w until word one leaves
module la32r_inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rj,
  input  logic [4:0]       in_rk,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [31:0] ERR_WORD = 32'h002A0000;

  typedef enum logic {S_IDLE, S_EMIT2} state_t;

  typedef enum logic [3:0] {
    C_3R, C_UI5, C_SI12, C_UI12, C_SI20, C_OFF16, C_OFF26, C_LI, C_NOP, C_ILL
  } cls_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic             out_err_q, out_err_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] base;
  cls_t        cls;
  logic [31:0] enc_word, enc_pend;
  logic        enc_ok, enc_two;
  logic        si12_ok, ui12_ok, ui5_ok, si20_ok, off16_ok, off26_ok;
  logic [31:0] f_rd, f_rj, f_rk, f_i12, f_off16;
  logic        accept, xfer;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid_q && out_ready;

  // Map op code to its base word and field layout class
  always_comb begin
    base = 32'h0;
    cls  = C_ILL;
    case (in_op)
      6'd0:  begin base = 32'h00100000; cls = C_3R;    end
      6'd1:  begin base = 32'h00110000; cls = C_3R;    end
      6'd2:  begin base = 32'h00120000; cls = C_3R;    end
      6'd3:  begin base = 32'h00128000; cls = C_3R;    end
      6'd4:  begin base = 32'h00140000; cls = C_3R;    end
      6'd5:  begin base = 32'h00148000; cls = C_3R;    end
      6'd6:  begin base = 32'h00150000; cls = C_3R;    end
      6'd7:  begin base = 32'h00158000; cls = C_3R;    end
      6'd8:  begin base = 32'h00170000; cls = C_3R;    end
      6'd9:  begin base = 32'h00178000; cls = C_3R;    end
      6'd10: begin base = 32'h00180000; cls = C_3R;    end
      6'd11: begin base = 32'h00408000; cls = C_UI5;   end
      6'd12: begin base = 32'h00448000; cls = C_UI5;   end
      6'd13: begin base = 32'h00488000; cls = C_UI5;   end
      6'd14: begin base = 32'h02000000; cls = C_SI12;  end
      6'd15: begin base = 32'h02400000; cls = C_SI12;  end
      6'd16: begin base = 32'h02800000; cls = C_SI12;  end
      6'd17: begin base = 32'h03400000; cls = C_UI12;  end
      6'd18: begin base = 32'h03800000; cls = C_UI12;  end
      6'd19: begin base = 32'h03C00000; cls = C_UI12;  end
      6'd20: begin base = 32'h14000000; cls = C_SI20;  end
      6'd21: begin base = 32'h1C000000; cls = C_SI20;  end
      6'd22: begin base = 32'h28000000; cls = C_SI12;  end
      6'd23: begin base = 32'h28400000; cls = C_SI12;  end
      6'd24: begin base = 32'h28800000; cls = C_SI12;  end
      6'd25: begin base = 32'h29000000; cls = C_SI12;  end
      6'd26: begin base = 32'h29400000; cls = C_SI12;  end
      6'd27: begin base = 32'h29800000; cls = C_SI12;  end
      6'd28: begin base = 32'h2A000000; cls = C_SI12;  end
      6'd29: begin base = 32'h2A400000; cls = C_SI12;  end
      6'd30: begin base = 32'h4C000000; cls = C_OFF16; end
      6'd31: begin base = 32'h50000000; cls = C_OFF26; end
      6'd32: begin base = 32'h54000000; cls = C_OFF26; end
      6'd33: begin base = 32'h58000000; cls = C_OFF16; end
      6'd34: begin base = 32'h5C000000; cls = C_OFF16; end
      6'd35: begin base = 32'h60000000; cls = C_OFF16; end
      6'd36: begin base = 32'h64000000; cls = C_OFF16; end
      6'd37: begin base = 32'h68000000; cls = C_OFF16; end
      6'd38: begin base = 32'h6C000000; cls = C_OFF16; end
      6'd39: begin base = 32'h0;        cls = C_LI;    end
      6'd40: begin base = 32'h03400000; cls = C_NOP;   end
      default: begin base = 32'h0;      cls = C_ILL;   end
    endcase
  end

  // Range checks, field packing and li.w split
  always_comb begin
    si12_ok  = (&in_imm[31:11]) || (~|in_imm[31:11]);
    ui12_ok  = ~|in_imm[31:12];
    ui5_ok   = ~|in_imm[31:5];
    si20_ok  = (&in_imm[31:19]) || (~|in_imm[31:19]);
    off16_ok = (~|in_imm[1:0]) && ((&in_imm[31:17]) || (~|in_imm[31:17]));
    off26_ok = (~|in_imm[1:0]) && ((&in_imm[31:27]) || (~|in_imm[31:27]));

    f_rd    = {27'b0, in_rd};
    f_rj    = {22'b0, in_rj, 5'b0};
    f_rk    = {17'b0, in_rk, 10'b0};
    f_i12   = {10'b0, in_imm[11:0], 10'b0};
    f_off16 = {6'b0, in_imm[17:2], 10'b0};

    enc_word = 32'h0;
    enc_ok   = 1'b0;
    enc_two  = 1'b0;
    enc_pend = 32'h03800000 | f_i12 | {22'b0, in_rd, 5'b0} | f_rd;
    case (cls)
      C_3R: begin
        enc_word = base | f_rk | f_rj | f_rd;
        enc_ok   = 1'b1;
      end
      C_UI5: begin
        enc_word = base | {17'b0, in_imm[4:0], 10'b0} | f_rj | f_rd;
        enc_ok   = ui5_ok;
      end
      C_SI12: begin
        enc_word = base | f_i12 | f_rj | f_rd;
        enc_ok   = si12_ok;
      end
      C_UI12: begin
        enc_word = base | f_i12 | f_rj | f_rd;
        enc_ok   = ui12_ok;
      end
      C_SI20: begin
        enc_word = base | {7'b0, in_imm[19:0], 5'b0} | f_rd;
        enc_ok   = si20_ok;
      end
      C_OFF16: begin
        enc_word = base | f_off16 | f_rj | f_rd;
        enc_ok   = off16_ok;
      end
      C_OFF26: begin
        enc_word = base | f_off16 | {22'b0, in_imm[27:18]};
        enc_ok   = off26_ok;
      end
      C_LI: begin
        enc_ok = 1'b1;
        if (si12_ok) begin
          enc_word = 32'h02800000 | f_i12 | f_rd;
        end else begin
          enc_word = 32'h14000000 | {7'b0, in_imm[31:12], 5'b0} | f_rd;
          enc_two  = |in_imm[11:0];
        end
      end
      C_NOP: begin
        enc_word = base;
        enc_ok   = 1'b1;
      end
      default: begin
        enc_word = ERR_WORD;
        enc_ok   = 1'b0;
      end
    endcase
    if (!enc_ok) begin
      enc_word = ERR_WORD;
      enc_two  = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && enc_two) state_d = S_EMIT2;
      S_EMIT2: if (xfer)              state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  end

  // Output register, pending ori word and transfer counter next values
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_word;
      out_err_d   = !enc_ok;
      if (enc_two) pend_d = enc_pend;
    end else if (state_q == S_EMIT2 && xfer) begin
      out_valid_d = 1'b1;
      out_inst_d  = pend_q;
      out_err_d   = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_err_q   <= 1'b0;
      pend_q      <= 32'h0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_la32r_inst_encoder.sv
// Testbench for la32r_inst_encoder: directed cases plus randomized traffic
// checked against an arithmetic reference model and an expected-word queue.
module tb_la32r_inst_encoder;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_op;
  logic [4:0]       in_rd, in_rj, in_rk;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] out_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  la32r_inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BASE [0:40] = '{
    32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00140000,
    32'h00148000, 32'h00150000, 32'h00158000, 32'h00170000, 32'h00178000,
    32'h00180000, 32'h00408000, 32'h00448000, 32'h00488000, 32'h02000000,
    32'h02400000, 32'h02800000, 32'h03400000, 32'h03800000, 32'h03C00000,
    32'h14000000, 32'h1C000000, 32'h28000000, 32'h28400000, 32'h28800000,
    32'h29000000, 32'h29400000, 32'h29800000, 32'h2A000000, 32'h2A400000,
    32'h4C000000, 32'h50000000, 32'h54000000, 32'h58000000, 32'h5C000000,
    32'h60000000, 32'h64000000, 32'h68000000, 32'h6C000000, 32'h00000000,
    32'h03400000};

  typedef struct {
    logic [31:0] w;
    logic        e;
  } word_t;

  // Reference: words an op should produce, from value ranges and arithmetic.
  function automatic void model(input int op, input int rd, input int rj,
                                input int rk, input logic [31:0] imm,
                                output int n, output logic [31:0] w0,
                                output logic e0, output logic [31:0] w1);
    longint s, r;
    bit ok;
    s  = longint'($signed(imm));
    r  = 0;
    ok = 1;
    n  = 1;
    w1 = 32'h0;
    if (op <= 10) begin
      r = BASE[op] + rk * 1024 + rj * 32 + rd;
    end else if (op <= 13) begin
      ok = (s >= 0 && s <= 31);
      r  = BASE[op] + s * 1024 + rj * 32 + rd;
    end else if ((op >= 14 && op <= 16) || (op >= 22 && op <= 29)) begin
      ok = (s >= -2048 && s <= 2047);
      r  = BASE[op] + (s & 4095) * 1024 + rj * 32 + rd;
    end else if (op >= 17 && op <= 19) begin
      ok = (s >= 0 && s <= 4095);
      r  = BASE[op] + s * 1024 + rj * 32 + rd;
    end else if (op == 20 || op == 21) begin
      ok = (s >= -524288 && s <= 524287);
      r  = BASE[op] + (s & 64'hFFFFF) * 32 + rd;
    end else if (op == 30 || (op >= 33 && op <= 38)) begin
      ok = ((s & 3) == 0) && s >= -131072 && s <= 131068;
      r  = BASE[op] + ((s >>> 2) & 64'hFFFF) * 1024 + rj * 32 + rd;
    end else if (op == 31 || op == 32) begin
      ok = ((s & 3) == 0) && s >= -134217728 && s <= 134217724;
      r  = BASE[op] + ((s >>> 2) & 64'hFFFF) * 1024 + ((s >>> 18) & 64'h3FF);
    end else if (op == 39) begin
      if (s >= -2048 && s <= 2047) begin
        r = 64'h02800000 + (s & 4095) * 1024 + rd;
      end else begin
        r = 64'h14000000 + ((s >>> 12) & 64'hFFFFF) * 32 + rd;
        if ((s & 4095) != 0) begin
          n  = 2;
          w1 = 32'(64'h03800000 + (s & 4095) * 1024 + rd * 32 + rd);
        end
      end
    end else if (op == 40) begin
      r = 64'h03400000;
    end else begin
      ok = 0;
    end
    w0 = ok ? r[31:0] : 32'h002A0000;
    e0 = !ok;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_op    = 'x;
    in_rd    = 'x;
    in_rj    = 'x;
    in_rk    = 'x;
    in_imm   = 'x;
  endtask

  // Present one request at a negedge, wait (bounded) for acceptance, then
  // return 1 time unit after the accepting edge.
  task automatic drive_req(input int op, input int rd, input int rj,
                           input int rk, input logic [31:0] imm);
    bit got = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 6'(op);
    in_rd    = 5'(rd);
    in_rj    = 5'(rj);
    in_rk    = 5'(rk);
    in_imm   = imm;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (in_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d in_ready stayed %b, needed 1", op, in_ready);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", out_valid); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h need 00000000", out_inst); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", out_err); end
    n_checks++; if (out_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d need 0", out_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b need 1", in_ready); end
    // Garbage on inputs while in_valid is low must do nothing
    repeat (3) begin
      @(negedge clk);
      in_op = 6'($urandom); in_imm = $urandom; in_rd = 5'($urandom);
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_cnt !== '0) begin
        n_fail++; $display("FAIL idle_inputs: valid %b cnt %0d need 0 0", out_valid, out_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_add();
    drive_req(0, 1, 2, 3, 32'h0);
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00100C41 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL add_word: valid %b inst %h err %b need 1 00100C41 0", out_valid, out_inst, out_err);
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_cnt: cnt %0d valid %b need 1 0", out_cnt, out_valid);
    end
  endtask

  task automatic test_li_two();
    logic [CNT_W-1:0] c0;
    out_ready = 1'b1;
    c0 = out_cnt;
    drive_req(39, 4, 0, 0, 32'h12345678);
    n_checks++; if (out_inst !== 32'h142468A4 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL li2_first: inst %h valid %b need 142468A4 1", out_inst, out_valid);
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL li2_busy: in_ready %b need 0", in_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (out_inst !== 32'h0399E084 || out_valid !== 1'b1 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL li2_second: inst %h valid %b err %b need 0399E084 1 0", out_inst, out_valid, out_err);
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_cnt !== c0 + 16'd2) begin
      n_fail++; $display("FAIL li2_done: valid %b cnt %0d need 0 %0d", out_valid, out_cnt, c0 + 16'd2);
    end
  endtask

  task automatic test_li_single();
    drive_req(39, 5, 0, 0, 32'hFFFFFFFF);
    n_checks++; if (out_inst !== 32'h02BFFC05 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL li_neg1: inst %h in_ready %b need 02BFFC05 1", out_inst, in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL li_neg1_single: valid %b need 0", out_valid); end
    drive_req(39, 5, 0, 0, 32'h00003000);
    n_checks++; if (out_inst !== 32'h14000065 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL li_3000: inst %h in_ready %b need 14000065 1", out_inst, in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL li_3000_single: valid %b need 0", out_valid); end
  endtask

  task automatic test_ranges();
    int          op_t  [6] = '{33, 33, 16, 32, 11, 17};
    logic [31:0] imm_t [6] = '{32'd8, 32'd6, 32'd2048, 32'hFFFFFFFC, 32'd32, 32'hFFFFFFFF};
    logic [31:0] exp_t [6] = '{32'h58000822, 32'h002A0000, 32'h002A0000, 32'h57FFFFFF, 32'h002A0000, 32'h002A0000};
    logic        err_t [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive_req(op_t[i], 2, 1, 0, imm_t[i]);
      n_checks++; if (out_inst !== exp_t[i] || out_err !== err_t[i]) begin
        n_fail++; $display("FAIL range_%0d: inst %h err %b need %h %b", i, out_inst, out_err, exp_t[i], err_t[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] c0;
    @(negedge clk);
    out_ready = 1'b0;
    c0 = out_cnt;
    drive_req(39, 4, 0, 0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_inst !== 32'h142468A4 || out_valid !== 1'b1 || in_ready !== 1'b0 || out_cnt !== c0) begin
        n_fail++; $display("FAIL bp_hold_%0d: inst %h valid %b ready %b cnt %0d", i, out_inst, out_valid, in_ready, out_cnt);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_inst !== 32'h0399E084 || out_valid !== 1'b1 || out_cnt !== c0 + 16'd1) begin
      n_fail++; $display("FAIL bp_second: inst %h valid %b cnt %0d need 0399E084 1 %0d", out_inst, out_valid, out_cnt, c0 + 16'd1);
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_cnt !== c0 + 16'd2) begin
      n_fail++; $display("FAIL bp_done: valid %b cnt %0d need 0 %0d", out_valid, out_cnt, c0 + 16'd2);
    end
  endtask

  task automatic test_reset_emit2();
    bool_dummy: begin end
    @(negedge clk);
    out_ready = 1'b0;
    drive_req(39, 4, 0, 0, 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_emit2: valid %b cnt %0d ready %b need 0 0 1", out_valid, out_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_discard_%0d: valid %b inst %h need valid 0", i, out_valid, out_inst);
      end
    end
    drive_req(50, 1, 1, 1, 32'h0);
    n_checks++; if (out_inst !== 32'h002A0000 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_op: inst %h err %b need 002A0000 1", out_inst, out_err);
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_cnt: cnt %0d need 1", out_cnt); end
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 40));
      3: return ($urandom & 32'h0007FFFE) - 32'h00040000;
      4: return ($urandom & 32'h1FFFFFFC) - 32'h10000000;
      default: return $urandom & 32'hFFFFF000;
    endcase
  endfunction

  task automatic test_random();
    word_t       q[$];
    word_t       wd;
    logic [CNT_W-1:0] cnt_exp;
    bit          exp_ready, xfer, acc;
    int          n;
    logic [31:0] w0, w1;
    logic        e0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_exp = '0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      if (cyc < 1190) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = ($urandom_range(0, 2) != 0);
        in_op     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 41));
        in_rd     = 5'($urandom);
        in_rj     = 5'($urandom);
        in_rk     = 5'($urandom);
        in_imm    = rand_imm();
      end else begin
        out_ready = 1'b1;
        idle_inputs();
      end
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      n_checks++; if (out_valid !== (q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b need %b", cyc, out_valid, q.size() > 0);
      end
      n_checks++; if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready c%0d: got %b need %b", cyc, in_ready, exp_ready);
      end
      n_checks++; if (out_cnt !== cnt_exp) begin
        n_fail++; $display("FAIL rnd_cnt c%0d: got %0d need %0d", cyc, out_cnt, cnt_exp);
      end
      if (q.size() > 0) begin
        n_checks++; if (out_inst !== q[0].w || out_err !== q[0].e) begin
          n_fail++; $display("FAIL rnd_word c%0d: inst %h err %b need %h %b", cyc, out_inst, out_err, q[0].w, q[0].e);
        end
      end
      xfer = (q.size() > 0) && out_ready;
      acc  = in_valid && exp_ready;
      if (acc) model(int'(in_op), int'(in_rd), int'(in_rj), int'(in_rk), in_imm, n, w0, e0, w1);
      @(posedge clk);
      if (xfer) begin
        void'(q.pop_front());
        cnt_exp = cnt_exp + 1'b1;
      end
      if (acc) begin
        wd.w = w0; wd.e = e0; q.push_back(wd);
        if (n == 2) begin wd.w = w1; wd.e = 1'b0; q.push_back(wd); end
      end
    end
    #1;
    n_checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: %0d words still expected, valid %b", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_li_two();
    test_li_single();
    test_ranges();
    test_backpressure();
    test_reset_emit2();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
